// File: rtl/alu_sequencer_pkg.sv
// ============================================================================
// alu_sequencer_pkg : shared ALU control types and sequencer state encoding
// Revision: 1.0
// ============================================================================
`default_nettype none

package alu_sequencer_pkg;

  localparam int REG_COUNT = 4;
  localparam int DATA_W    = 8;
  localparam int ADDR_W    = $clog2(REG_COUNT);

  typedef enum logic [3:0] {
    ADD = 4'd0, SUB, AND, OR, XOR, NOT, SHL, SHR, ROL, ROR, MUL, DIV
  } alu_op_e;

  typedef enum logic [2:0] {
    NONE = 3'd0, ZERO, CARRY, NEGATIVE, REMAINDER
  } alu_flag_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WRITE = 2'd2
  } seq_state_e;

  function automatic logic is_unary(input alu_op_e op);
    return op inside {SHL, ROL, SHR, ROR, NOT};
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_sequencer.sv
// ============================================================================
// alu_sequencer : 4x8 register file feeding a sibling ALU, 3-cycle issue FSM
// Revision: 1.0
// ============================================================================
`default_nettype none

module alu_sequencer
  import alu_sequencer_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  alu_op_e           req_op,
  input  logic [ADDR_W-1:0] req_dst,
  input  logic [ADDR_W-1:0] req_src1,
  input  logic [ADDR_W-1:0] req_src2,
  input  logic              req_imm_en,
  input  logic [DATA_W-1:0] req_imm,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] alu_register1,
  output logic [DATA_W-1:0] alu_register2,
  output alu_op_e           alu_op,
  output logic              alu_enable,
  input  logic [DATA_W-1:0] alu_result,
  input  alu_flag_e         alu_flag,
  output logic              done,
  output logic              done_err,
  output alu_flag_e         flag_q
);

  seq_state_e        r_state;
  seq_state_e        w_state_nxt;
  logic [DATA_W-1:0] r_regs [REG_COUNT];
  alu_op_e           r_op;
  logic [ADDR_W-1:0] r_dst;
  logic [DATA_W-1:0] r_opnd1;
  logic [DATA_W-1:0] r_opnd2;
  logic              r_div0;
  alu_flag_e         r_flag;

  logic              w_accept;
  logic [DATA_W-1:0] w_opnd2;
  logic              w_div0;

  assign w_accept = req_valid && (r_state == IDLE);
  assign w_opnd2  = is_unary(req_op) ? '0 : (req_imm_en ? req_imm : r_regs[req_src2]);
  // A divide by zero never reaches the ALU; it completes with an error instead.
  assign w_div0   = (req_op == DIV) && (w_opnd2 == '0);

  assign rd_data       = r_regs[rd_addr];
  assign alu_register1 = r_opnd1;
  assign alu_register2 = r_opnd2;
  assign alu_op        = r_op;
  assign flag_q        = r_flag;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    req_ready   = 1'b0;
    alu_enable  = 1'b0;
    done        = 1'b0;
    done_err    = 1'b0;
    case (r_state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          w_state_nxt = w_div0 ? WRITE : ISSUE;
        end
      end
      ISSUE: begin
        alu_enable  = 1'b1;
        w_state_nxt = WRITE;
      end
      WRITE: begin
        alu_enable  = !r_div0;
        done        = 1'b1;
        done_err    = r_div0;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Loads only land in idle cycles with no accepted request, so no write-port conflict.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        r_regs[i] <= '0;
      end
      r_op    <= ADD;
      r_dst   <= '0;
      r_opnd1 <= '0;
      r_opnd2 <= '0;
      r_div0  <= 1'b0;
      r_flag  <= NONE;
    end else if (w_accept) begin
      r_op    <= req_op;
      r_dst   <= req_dst;
      r_opnd1 <= r_regs[req_src1];
      r_opnd2 <= w_opnd2;
      r_div0  <= w_div0;
    end else if (r_state == WRITE) begin
      if (!r_div0) begin
        r_regs[r_dst] <= alu_result;
        r_flag        <= alu_flag;
      end
    end else if (load_en && (r_state == IDLE)) begin
      r_regs[load_addr] <= load_data;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_sequencer.sv
// ============================================================================
// tb_alu_sequencer : directed bench for alu_sequencer with a sibling ALU model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_alu_sequencer;
  import alu_sequencer_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  alu_op_e     req_op;
  logic [1:0]  req_dst, req_src1, req_src2;
  logic        req_imm_en;
  logic [7:0]  req_imm;
  logic        load_en;
  logic [1:0]  load_addr;
  logic [7:0]  load_data;
  logic [1:0]  rd_addr;
  logic [7:0]  rd_data;
  logic [7:0]  alu_register1, alu_register2;
  alu_op_e     alu_op;
  logic        alu_enable;
  logic [7:0]  alu_result = 8'h00;
  alu_flag_e   alu_flag = NONE;
  logic        done, done_err;
  alu_flag_e   flag_q;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clock = ~clock;

  alu_sequencer dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_dst(req_dst), .req_src1(req_src1), .req_src2(req_src2),
    .req_imm_en(req_imm_en), .req_imm(req_imm),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .alu_register1(alu_register1), .alu_register2(alu_register2),
    .alu_op(alu_op), .alu_enable(alu_enable),
    .alu_result(alu_result), .alu_flag(alu_flag),
    .done(done), .done_err(done_err), .flag_q(flag_q)
  );

  // Sibling ALU: registers its result on every enabled edge.
  logic [8:0] m_sum;
  logic [7:0] m_q;
  always @(posedge clock) begin
    if (alu_enable) begin
      case (alu_op)
        ADD: begin
          m_sum = {1'b0, alu_register1} + {1'b0, alu_register2};
          alu_result <= m_sum[7:0];
          alu_flag   <= m_sum[8] ? CARRY : ((m_sum[7:0] == 8'h00) ? ZERO : NONE);
        end
        SUB: begin
          m_q = alu_register1 - alu_register2;
          alu_result <= m_q;
          alu_flag   <= (m_q == 8'h00) ? ZERO : ((alu_register1 < alu_register2) ? CARRY : NONE);
        end
        DIV: begin
          m_q = (alu_register2 == 8'h00) ? 8'hFF : alu_register1 / alu_register2;
          alu_result <= m_q;
          alu_flag   <= ((alu_register2 != 8'h00) && ((alu_register1 % alu_register2) != 8'h00))
                        ? REMAINDER : ((m_q == 8'h00) ? ZERO : NONE);
        end
        NOT: begin
          alu_result <= ~alu_register1;
          alu_flag   <= (alu_register1 == 8'hFF) ? ZERO : NONE;
        end
        default: begin
          alu_result <= 8'h00;
          alu_flag   <= NONE;
        end
      endcase
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic rchk(input string tag, input logic [1:0] addr, input logic [7:0] exp);
    rd_addr = addr;
    #1;
    chk(tag, 32'(rd_data), 32'(exp));
  endtask

  task automatic load(input logic [1:0] addr, input logic [7:0] data);
    load_en   = 1'b1;
    load_addr = addr;
    load_data = data;
    @(posedge clock); #1;
    load_en   = 1'b0;
  endtask

  task automatic issue(input alu_op_e op, input logic [1:0] dst, input logic [1:0] s1,
                       input logic [1:0] s2, input logic imm_en, input logic [7:0] imm);
    req_op     = op;
    req_dst    = dst;
    req_src1   = s1;
    req_src2   = s2;
    req_imm_en = imm_en;
    req_imm    = imm;
    req_valid  = 1'b1;
    @(posedge clock); #1;
    req_valid  = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_op = ADD; req_dst = '0; req_src1 = '0;
    req_src2 = '0; req_imm_en = 1'b0; req_imm = '0; load_en = 1'b0; load_addr = '0;
    load_data = '0; rd_addr = '0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_ready", 32'(req_ready), 32'(1));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_enable", 32'(alu_enable), 32'(0));
    chk("rst_op", 32'(alu_op), 32'(ADD));
    chk("rst_flag", 32'(flag_q), 32'(NONE));
    rchk("rst_r0", 2'd0, 8'h00);
    reset = 1'b0;

    // ADD r2 = 200 + 100 -> 44 with carry
    load(2'd0, 8'd200);
    load(2'd1, 8'd100);
    issue(ADD, 2'd2, 2'd0, 2'd1, 1'b0, 8'h00);
    chk("add_issue_ready", 32'(req_ready), 32'(0));
    chk("add_issue_en", 32'(alu_enable), 32'(1));
    chk("add_issue_done", 32'(done), 32'(0));
    chk("add_opnd1", 32'(alu_register1), 32'(200));
    chk("add_opnd2", 32'(alu_register2), 32'(100));
    @(posedge clock); #1;
    chk("add_done", 32'(done), 32'(1));
    chk("add_done_err", 32'(done_err), 32'(0));
    chk("add_write_en", 32'(alu_enable), 32'(1));
    @(posedge clock); #1;
    chk("add_idle_done", 32'(done), 32'(0));
    chk("add_idle_ready", 32'(req_ready), 32'(1));
    chk("add_idle_en", 32'(alu_enable), 32'(0));
    chk("add_flag", 32'(flag_q), 32'(CARRY));
    rchk("add_r2", 2'd2, 8'd44);

    // DIV r1 = 7 / imm 2 -> 3 with remainder
    load(2'd0, 8'd7);
    issue(DIV, 2'd1, 2'd0, 2'd3, 1'b1, 8'd2);
    chk("div_opnd2", 32'(alu_register2), 32'(2));
    repeat (2) @(posedge clock);
    #1;
    chk("div_flag", 32'(flag_q), 32'(REMAINDER));
    rchk("div_r1", 2'd1, 8'd3);

    // SUB r3 = r0 - r0, with a load during ISSUE and a request held over WRITE
    load(2'd3, 8'h11);
    load(2'd0, 8'd5);
    issue(SUB, 2'd3, 2'd0, 2'd0, 1'b0, 8'h00);
    load_en = 1'b1; load_addr = 2'd0; load_data = 8'd99;
    @(posedge clock); #1;
    load_en = 1'b0;
    chk("sub_done", 32'(done), 32'(1));
    req_op = ADD; req_dst = 2'd2; req_src1 = 2'd3; req_src2 = 2'd0; req_imm_en = 1'b0;
    req_valid = 1'b1;
    #1;
    chk("held_not_ready", 32'(req_ready), 32'(0));
    @(posedge clock); #1;
    chk("held_idle_ready", 32'(req_ready), 32'(1));
    chk("sub_flag", 32'(flag_q), 32'(ZERO));
    rchk("sub_r3", 2'd3, 8'd0);
    rchk("load_ignored_r0", 2'd0, 8'd5);
    @(posedge clock); #1;
    req_valid = 1'b0;
    chk("held_accepted", 32'(req_ready), 32'(0));
    chk("held_opnd1", 32'(alu_register1), 32'(0));
    chk("held_opnd2", 32'(alu_register2), 32'(5));
    repeat (2) @(posedge clock);
    #1;
    rchk("held_r2", 2'd2, 8'd5);
    chk("held_flag", 32'(flag_q), 32'(NONE));

    // DIV by immediate zero: error completion, no writeback
    issue(DIV, 2'd1, 2'd0, 2'd0, 1'b1, 8'd0);
    chk("div0_done", 32'(done), 32'(1));
    chk("div0_done_err", 32'(done_err), 32'(1));
    chk("div0_enable", 32'(alu_enable), 32'(0));
    @(posedge clock); #1;
    chk("div0_after_done", 32'(done), 32'(0));
    chk("div0_after_err", 32'(done_err), 32'(0));
    chk("div0_ready", 32'(req_ready), 32'(1));
    chk("div0_flag", 32'(flag_q), 32'(NONE));
    rchk("div0_r1", 2'd1, 8'd3);

    // Unary op forces operand2 to zero
    issue(NOT, 2'd0, 2'd1, 2'd2, 1'b0, 8'h00);
    chk("not_opnd1", 32'(alu_register1), 32'(3));
    chk("not_opnd2", 32'(alu_register2), 32'(0));
    repeat (2) @(posedge clock);
    #1;
    rchk("not_r0", 2'd0, 8'hFC);

    // Reset during WRITE aborts the operation
    issue(ADD, 2'd2, 2'd0, 2'd1, 1'b0, 8'h00);
    @(posedge clock); #1;
    chk("abort_pre_done", 32'(done), 32'(1));
    reset = 1'b1;
    #1;
    chk("abort_done", 32'(done), 32'(0));
    chk("abort_enable", 32'(alu_enable), 32'(0));
    chk("abort_ready", 32'(req_ready), 32'(1));
    @(posedge clock); #1;
    chk("abort_flag", 32'(flag_q), 32'(NONE));
    rchk("abort_r0", 2'd0, 8'h00);
    rchk("abort_r1", 2'd1, 8'h00);
    rchk("abort_r2", 2'd2, 8'h00);
    rchk("abort_r3", 2'd3, 8'h00);
    reset = 1'b0;
    chk("release_ready", 32'(req_ready), 32'(1));
    issue(ADD, 2'd1, 2'd0, 2'd0, 1'b0, 8'h00);
    chk("first_accept", 32'(req_ready), 32'(0));
    chk("first_accept_en", 32'(alu_enable), 32'(1));
    repeat (2) @(posedge clock);
    #1;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
